tt_uart_mvm_core: RTL and testbench
===================================

// Module: tt_uart_mvm_core
// PURPOSE
// - Tiny Tapeout user block: UART-in, UART-out signed matrix-vector multiplier.
// - Receives a packed K matrix (R x C) and x vector (C) as UART bytes.
// - Computes y = K*x in two's complement and transmits y back as UART bytes.
// - Top-level pad wrapper: ui_in[0] = RX, uo_out[0] = TX.
// PARAMETERS
// - CLOCKS_PER_PULSE  434  clocks per UART bit (50 MHz / 115200)
// - BITS_PER_WORD     8    UART data bits per frame
// - PACKET_SIZE_TX    13   TX frame length: 1 start + 8 data + 4 stop/idle-high bits
// - R                 2    matrix rows
// - C                 2    matrix columns
// - W_X               4    x element width, signed
// - W_K               4    K element width, signed
// - W_Y_OUT           8    transmitted y element width
// PORTS
// - clk      in   1  system clock
// - rst_n    in   1  asynchronous reset, asserted HIGH (active-high despite name)
// - ena      in   1  power-good; ignored
// - ui_in    in   8  bit 0 = UART RX (idle high); bits 7:1 unused
// - uo_out   out  8  bit 0 = UART TX (idle high); bits 7:1 = 0
// - uio_in   in   8  unused
// - uio_out  out  8  constant 0
// - uio_oe   out  8  constant 0 (all inputs)
// BEHAVIOUR
// - Reset: TX=1, RX/TX FSMs IDLE, byte counter=0, result/pending cleared. Partial frames lost.
// - RX FSM IDLE->START->DATA->STOP:
//   - Start = falling edge of synchronised RX (2-FF synchroniser).
//   - Sample at CLOCKS_PER_PULSE/2, then every CLOCKS_PER_PULSE; data LSB first.
//   - Stop bit 0: byte discarded, counter unchanged, FSM back to IDLE.
// - Input packet: N_KX = (R*C*W_K + C*W_X)/8 = 3 bytes; byte i fills bits [8i+7:8i].
//   - Packet bus = {K, x}: x[c] at bits [4c+3:4c] (byte 0).
//   - K[r][c] at bits 8 + 8r + 4c (byte 1 = row 0, byte 2 = row 1).
// - After byte 3: counter wraps to 0.
//   - y[r] = sum_c signed(K[r][c]) * signed(x[c]), full width W_X+W_K+clog2(C) = 9.
//   - Truncate y[r] to 8 LSBs (wrap; no saturation).
//   - Latch result within 2 clocks.
// - TX FSM IDLE->START->DATA->STOPPAD:
//   - Frame = 0 start bit, 8 data bits LSB first, 4 high bits; each bit CLOCKS_PER_PULSE clocks.
//   - Sends N_Y = 2 bytes: y[0] then y[1]; next frame starts immediately after previous padding.
//   - First start bit within 4 clocks of result latch.
// - RX and TX run concurrently; receiving continues during transmission.
//   - If a new result completes while TX busy: hold one pending result; send after current pair.
//   - A further result while pending is full overwrites the pending one.
// - Reset asserted mid-operation: immediate return to reset state, TX forced high.
// TESTING
// - Reset: hold rst_n=1 -> uo_out=0x01, uio_oe=0, uio_out=0; release, RX idle -> TX stays 1.
// - Bytes 0x21,0x43,0x65 (x=1,2; K=[3 4;5 6]) -> TX 0x0B then 0x11.
// - Bytes 0x1F,0x32,0x78 (x=-1,1; K=[2 3;-8 7]) -> TX 0x01 then 0x0F.
// - Overflow: bytes 0x88,0x88,0x88 (all -8) -> TX 0x80, 0x80 (128 wrapped).
// - TX framing: every frame has 0 start bit, 8 data bits, 4 high bits at 434-clock spacing.
// - Back-to-back: 10 random packets, 1-100 clock gaps -> each y pair matches software model in order.
// - Framing error: corrupt stop bit of one byte -> byte dropped; next 3 valid bytes yield correct y.

Source files
------------

// File: rtl/tt_uart_mvm_core_if.sv
// tt_uart_mvm_core_if
// Pad-level bundle of the Tiny Tapeout user block.
//   ena      : power-good from the harness (the core ignores it)
//   ui_in    : dedicated inputs, bit 0 = UART RX (idle high)
//   uo_out   : dedicated outputs, bit 0 = UART TX (idle high)
//   uio_in   : bidirectional pads, input side (unused)
//   uio_out  : bidirectional pads, output side (driven 0)
//   uio_oe   : bidirectional pad enables (0 = input)
// master = harness / testbench side, slave = core side.
interface tt_uart_mvm_core_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_uart_mvm_core.sv
// tt_uart_mvm_core
// UART-in / UART-out signed matrix-vector multiplier.
// A packet of N_KX bytes carries {K, x}; once complete, y = K*x is computed in
// two's complement, each y element is truncated to W_Y_OUT bits and the
// elements are sent back LSB-byte first over the TX line.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous reset, asserted HIGH
//   bus    : pad bundle (slave side); ui_in[0] = RX, uo_out[0] = TX
module tt_uart_mvm_core #(
  parameter int CLOCKS_PER_PULSE = 434,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13,
  parameter int R                = 2,
  parameter int C                = 2,
  parameter int W_X              = 4,
  parameter int W_K              = 4,
  parameter int W_Y_OUT          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tt_uart_mvm_core_if.slave bus
);

  localparam int N_KX  = (R*C*W_K + C*W_X) / BITS_PER_WORD;
  localparam int W_PKT = N_KX * BITS_PER_WORD;
  localparam int K_OFF = C * W_X;
  localparam int W_P   = W_X + W_K;
  localparam int W_Y   = W_X + W_K + $clog2(C);
  localparam int W_YB  = R * W_Y_OUT;
  localparam int N_Y   = W_YB / BITS_PER_WORD;
  localparam int N_PAD = PACKET_SIZE_TX - 1 - BITS_PER_WORD;

  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam int PW = (N_PAD > 1) ? $clog2(N_PAD) : 1;
  localparam int KW = (N_KX > 1) ? $clog2(N_KX) : 1;
  localparam int YW = (N_Y > 1) ? $clog2(N_Y) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [PW-1:0] PAD_LAST = PW'(N_PAD - 1);
  localparam logic [KW-1:0] KX_LAST  = KW'(N_KX - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(N_Y - 1);

  // ---------------------------------------------------------------------------
  // RX synchroniser and falling-edge detector. Flops reset to 1 (line idle)
  // so leaving reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.ui_in[0];
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM: IDLE -> START -> DATA -> STOP
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e                rx_state_q, rx_state_d;
  logic [CW-1:0]            rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]            rx_bit_q, rx_bit_d;
  logic [BITS_PER_WORD-1:0] rx_shift_q, rx_shift_d;
  logic                     rx_valid_q, rx_valid_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          // A line back high at mid-start is a glitch, not a frame.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          // LSB arrives first, so shift in from the top.
          rx_shift_d = {rx_sync_q, rx_shift_q[BITS_PER_WORD-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          // A low stop bit drops the byte silently.
          rx_valid_d = rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet assembly: byte i lands in pkt bits [8i+7:8i]. calc_q pulses the
  // cycle after the last byte, when pkt_q holds the complete packet.
  // ---------------------------------------------------------------------------
  logic [W_PKT-1:0] pkt_q, pkt_d;
  logic [KW-1:0]    kx_cnt_q, kx_cnt_d;
  logic             calc_q, calc_d;

  always_comb begin
    pkt_d    = pkt_q;
    kx_cnt_d = kx_cnt_q;
    calc_d   = 1'b0;
    if (rx_valid_q) begin
      for (int i = 0; i < N_KX; i++) begin
        if (kx_cnt_q == KW'(i)) pkt_d[i*BITS_PER_WORD +: BITS_PER_WORD] = rx_shift_q;
      end
      if (kx_cnt_q == KX_LAST) begin
        kx_cnt_d = '0;
        calc_d   = 1'b1;
      end else begin
        kx_cnt_d = kx_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pkt_q    <= '0;
      kx_cnt_q <= '0;
      calc_q   <= 1'b0;
    end else begin
      pkt_q    <= pkt_d;
      kx_cnt_q <= kx_cnt_d;
      calc_q   <= calc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Signed matrix-vector product. Each row is summed at full width W_Y and
  // then wrapped to W_Y_OUT bits (no saturation).
  // ---------------------------------------------------------------------------
  logic [W_YB-1:0] y_bus;
  genvar gi, gj;

  for (gi = 0; gi < R; gi++) begin : g_row
    logic signed [W_P-1:0] prod [C];
    logic        [W_Y-1:0] acc;
    logic                  unused_acc_msbs;

    for (gj = 0; gj < C; gj++) begin : g_col
      logic signed [W_K-1:0] k_el;
      logic signed [W_X-1:0] x_el;
      assign k_el     = pkt_q[K_OFF + (gi*C + gj)*W_K +: W_K];
      assign x_el     = pkt_q[gj*W_X +: W_X];
      assign prod[gj] = k_el * x_el;
    end

    always_comb begin
      acc = '0;
      for (int c = 0; c < C; c++) begin
        acc = acc + {{(W_Y-W_P){prod[c][W_P-1]}}, prod[c]};
      end
    end

    assign y_bus[gi*W_Y_OUT +: W_Y_OUT] = acc[W_Y_OUT-1:0];
    assign unused_acc_msbs = ^acc[W_Y-1:W_Y_OUT];
  end

  // ---------------------------------------------------------------------------
  // Result hand-off and TX FSM: IDLE -> START -> DATA -> STOPPAD.
  // A finished product always goes into the single pending slot (newest
  // wins); the TX FSM takes it whenever it is idle. The word being sent is
  // shifted right one bit per data bit, so after a byte the next byte is
  // already at the bottom.
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOPPAD} tx_state_e;

  logic [W_YB-1:0] pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  tx_state_e       tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]   tx_bit_q, tx_bit_d;
  logic [PW-1:0]   tx_pad_q, tx_pad_d;
  logic [YW-1:0]   tx_byte_q, tx_byte_d;
  logic [W_YB-1:0] tx_word_q, tx_word_d;
  logic            tx_q, tx_d;

  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q;
    tx_bit_d     = tx_bit_q;
    tx_pad_d     = tx_pad_q;
    tx_byte_d    = tx_byte_q;
    tx_word_d    = tx_word_q;
    tx_d         = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (pend_valid_q) begin
          tx_word_d    = pend_q;
          pend_valid_d = 1'b0;
          tx_byte_d    = '0;
          tx_cnt_d     = '0;
          tx_d         = 1'b0;
          tx_state_d   = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_word_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d  = '0;
          tx_word_d = tx_word_q >> 1;
          if (tx_bit_q == BIT_LAST) begin
            tx_pad_d   = '0;
            tx_d       = 1'b1;
            tx_state_d = TX_STOPPAD;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = tx_word_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOPPAD: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_pad_q == PAD_LAST) begin
            if (tx_byte_q == Y_LAST) begin
              tx_state_d = TX_IDLE;
            end else begin
              // Next byte of the same result follows with no idle gap.
              tx_byte_d  = tx_byte_q + 1'b1;
              tx_d       = 1'b0;
              tx_state_d = TX_START;
            end
          end else begin
            tx_pad_d = tx_pad_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
    // A new result wins over the IDLE-state take in the same cycle.
    if (calc_q) begin
      pend_d       = y_bus;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_pad_q     <= '0;
      tx_byte_q    <= '0;
      tx_word_q    <= '0;
      tx_q         <= 1'b1;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_pad_q     <= tx_pad_d;
      tx_byte_q    <= tx_byte_d;
      tx_word_q    <= tx_word_d;
      tx_q         <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pads
  // ---------------------------------------------------------------------------
  assign bus.uo_out  = {7'b0, tx_q};
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

  logic unused_pins;
  assign unused_pins = &{1'b0, bus.ena, bus.ui_in[7:1], bus.uio_in};

endmodule

// File: tb/tb_tt_uart_mvm_core.sv
// tb_tt_uart_mvm_core
// Drives UART packets into tt_uart_mvm_core and decodes its TX line with an
// independent UART receiver, comparing every received byte against y = K*x
// computed from the packet bytes with plain integer arithmetic.
module tb_tt_uart_mvm_core;

  localparam int CPP    = 20;
  localparam int FRAME  = 13 * CPP;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] exp_q [$];

  tt_uart_mvm_core_if bus ();

  tt_uart_mvm_core #(.CLOCKS_PER_PULSE(CPP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sx4(input logic [3:0] n);
    return n[3] ? int'(n) - 16 : int'(n);
  endfunction

  // y[r] = sum_c K[r][c]*x[c]; returned as {y1[7:0], y0[7:0]}.
  function automatic logic [15:0] model_y(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    int x0, x1, y0, y1;
    x0 = sx4(b0[3:0]);
    x1 = sx4(b0[7:4]);
    y0 = sx4(b1[3:0]) * x0 + sx4(b1[7:4]) * x1;
    y1 = sx4(b2[3:0]) * x0 + sx4(b2[7:4]) * x1;
    return {8'(y1), 8'(y0)};
  endfunction

  task automatic set_rx(input logic v);
    bus.ui_in = {7'b0, v};
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    set_rx(1'b0);
    repeat (CPP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(b[i]);
      repeat (CPP) @(negedge clk);
    end
    set_rx(stop_bit);
    repeat (CPP) @(negedge clk);
    set_rx(1'b1);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [15:0] y;
    send_byte(b0, 1'b1);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    send_byte(b1, 1'b1);
    repeat ($urandom_range(1, 20)) @(negedge clk);
    send_byte(b2, 1'b1);
    y = model_y(b0, b1, b2);
    exp_q.push_back(y[7:0]);
    exp_q.push_back(y[15:8]);
    $display("[TB] packet %02h %02h %02h -> expect y0=%02h y1=%02h", b0, b1, b2, y[7:0], y[15:8]);
  endtask

  task automatic pin_model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [15:0] lit);
    logic [15:0] y;
    y = model_y(b0, b1, b2);
    check("model_y0", {24'b0, y[7:0]}, {24'b0, lit[7:0]});
    check("model_y1", {24'b0, y[15:8]}, {24'b0, lit[15:8]});
  endtask

  // TX decoder: frame timing taken from the line alone.
  initial begin : tx_mon
    int          start_cyc;
    int          prev_start;
    int          frame_idx;
    logic [7:0]  b;
    logic [3:0]  pad;
    logic        st;
    logic [7:0]  e;
    frame_idx  = 0;
    prev_start = 0;
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      if (bus.uo_out[0] !== 1'b0) continue;
      start_cyc = cyc;
      repeat (CPP / 2) @(negedge clk);
      st = bus.uo_out[0];
      for (int i = 0; i < 8; i++) begin
        repeat (CPP) @(negedge clk);
        b[i] = bus.uo_out[0];
      end
      for (int p = 0; p < 4; p++) begin
        repeat (CPP) @(negedge clk);
        pad[p] = bus.uo_out[0];
      end
      check("tx_start_bit", {31'b0, st}, 32'd0);
      check("tx_pad_bits", {28'b0, pad}, 32'hF);
      check("uo_out_hi", {25'b0, bus.uo_out[7:1]}, 32'd0);
      if (frame_idx % 2 == 1)
        check("tx_pair_spacing", start_cyc - prev_start, FRAME);
      if (exp_q.size() == 0) begin
        check("tx_unexpected_frame", {24'b0, b}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {24'b0, b}, {24'b0, e});
        $display("[TB] tx frame %0d: byte %02h (expected %02h)", frame_idx, b, e);
      end
      prev_start = start_cyc;
      frame_idx++;
    end
  end

  initial begin : main
    int bad;
    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    set_rx(1'b1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_uo_out", {24'b0, bus.uo_out}, 32'h01);
    check("reset_uio_oe", {24'b0, bus.uio_oe}, 32'h00);
    check("reset_uio_out", {24'b0, bus.uio_out}, 32'h00);
    rst_n = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.uo_out !== 8'h01) bad++;
    end
    check("idle_tx_high", bad, 0);

    pin_model(8'h21, 8'h43, 8'h65, 16'h110B);
    pin_model(8'h1F, 8'h32, 8'h78, 16'h0F01);
    pin_model(8'h88, 8'h88, 8'h88, 16'h8080);

    send_packet(8'h21, 8'h43, 8'h65);
    repeat (30) @(negedge clk);
    send_packet(8'h1F, 8'h32, 8'h78);
    repeat (30) @(negedge clk);
    send_packet(8'h88, 8'h88, 8'h88);

    for (int n = 0; n < 10; n++) begin
      repeat ($urandom_range(1, 100)) @(negedge clk);
      send_packet(8'($urandom), 8'($urandom), 8'($urandom));
    end

    // A byte with a low stop bit must vanish without shifting the packet.
    repeat (50) @(negedge clk);
    $display("[TB] sending byte 5a with a low stop bit");
    send_byte(8'h5A, 1'b0);
    repeat ($urandom_range(5, 40)) @(negedge clk);
    send_packet(8'($urandom), 8'($urandom), 8'($urandom));

    for (int t = 0; t < 5000 && exp_q.size() != 0; t++) @(negedge clk);
    check("tx_drained", exp_q.size(), 0);
    repeat (4 * CPP) @(negedge clk);
    check("final_uo_out", {24'b0, bus.uo_out}, 32'h01);
    check("final_uio_oe", {24'b0, bus.uio_oe}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
